// File: rtl/cnc_step_pulse_gen.sv
// STEP/DIR pulse generator for one stepper axis: latches a motion command, applies a
// DIR setup delay, then emits clamped, evenly spaced STEP pulses with status readback.
module cnc_step_pulse_gen #(
    parameter int CNT_WIDTH        = 32,
    parameter int PW_WIDTH         = 16,
    parameter int DIR_SETUP_CYCLES = 100
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_dir,
    input  logic [CNT_WIDTH-1:0] cmd_steps,
    input  logic [CNT_WIDTH-1:0] cmd_period,
    input  logic [PW_WIDTH-1:0]  cmd_pulse_width,
    input  logic                 abort,
    output logic                 step_out,
    output logic                 dir_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] steps_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [PW_WIDTH-1:0]  PW_ONE     = PW_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] SETUP_LOAD = CNT_WIDTH'(DIR_SETUP_CYCLES - 1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  steps_q, steps_d;
    logic [PW_WIDTH-1:0]   pw_q, pw_d;
    logic [CNT_WIDTH-1:0]  low_q, low_d;
    logic [CNT_WIDTH-1:0]  steps_done_q, steps_done_d;
    logic                  abort_pend_q, abort_pend_d;
    logic                  dir_q, dir_d;
    logic                  step_q, step_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [PW_WIDTH-1:0]   pw_eff_s;
    logic [CNT_WIDTH-1:0]  pw_ext_s;
    logic [CNT_WIDTH-1:0]  per_min_s;
    logic [CNT_WIDTH-1:0]  per_eff_s;
    logic [CNT_WIDTH-1:0]  pw_load_s;

    // Clamp the incoming pulse width and period so both phases last at least one cycle.
    always_comb begin
        if (cmd_pulse_width == '0) begin
            pw_eff_s = PW_ONE;
        end else begin
            pw_eff_s = cmd_pulse_width;
        end
        pw_ext_s  = CNT_WIDTH'(pw_eff_s);
        per_min_s = pw_ext_s + CNT_ONE;
        if (cmd_period < per_min_s) begin
            per_eff_s = per_min_s;
        end else begin
            per_eff_s = cmd_period;
        end
        pw_load_s = CNT_WIDTH'(pw_q) - CNT_ONE;
    end

    // Next-state, counter and output-register logic of the move sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        steps_d      = steps_q;
        pw_d         = pw_q;
        low_d        = low_q;
        steps_done_d = steps_done_q;
        abort_pend_d = abort_pend_q;
        dir_d        = dir_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    steps_d      = cmd_steps;
                    pw_d         = pw_eff_s;
                    low_d        = per_eff_s - pw_ext_s;
                    steps_done_d = '0;
                    abort_pend_d = 1'b0;
                    if (cmd_steps == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETUP;
                        dir_d   = cmd_dir;
                        cnt_d   = SETUP_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (cnt_q == '0) begin
                    state_d = S_HIGH;
                    cnt_d   = pw_load_s;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_HIGH: begin
                // An abort seen during the pulse is remembered so the pulse is never cut short.
                abort_pend_d = abort_pend_q | abort;
                if (cnt_q == '0) begin
                    steps_done_d = steps_done_q + CNT_ONE;
                    if (abort_pend_q || abort) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOW;
                        cnt_d   = low_q - CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_LOW: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (cnt_q == '0) begin
                    if (steps_done_q < steps_q) begin
                        state_d = S_HIGH;
                        cnt_d   = pw_load_s;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        step_d = (state_d == S_HIGH);
        busy_d = (state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_LOW);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset drops the pins at once and discards the move.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            steps_q      <= '0;
            pw_q         <= '0;
            low_q        <= '0;
            steps_done_q <= '0;
            abort_pend_q <= 1'b0;
            dir_q        <= 1'b0;
            step_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            steps_q      <= steps_d;
            pw_q         <= pw_d;
            low_q        <= low_d;
            steps_done_q <= steps_done_d;
            abort_pend_q <= abort_pend_d;
            dir_q        <= dir_d;
            step_q       <= step_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign step_out   = step_q;
    assign dir_out    = dir_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign steps_done = steps_done_q;

endmodule

// File: tb/tb_cnc_step_pulse_gen.sv
// Self-checking bench for cnc_step_pulse_gen: directed cases plus randomized moves,
// compared cycle by cycle against a pulse-timing model built from rise times.
module tb_cnc_step_pulse_gen;

    localparam int DS = 4;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [31:0] cmd_steps;
    logic [31:0] cmd_period;
    logic [15:0] cmd_pulse_width;
    logic        abort;
    logic        step_out;
    logic        dir_out;
    logic        busy;
    logic        done;
    logic [31:0] steps_done;

    int n_total;
    int n_bad;
    logic exp_dir;

    cnc_step_pulse_gen #(
        .CNT_WIDTH(32),
        .PW_WIDTH(16),
        .DIR_SETUP_CYCLES(DS)
    ) dut (
        .ACLK(clk),
        .ARESET(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir),
        .cmd_steps(cmd_steps),
        .cmd_period(cmd_period),
        .cmd_pulse_width(cmd_pulse_width),
        .abort(abort),
        .step_out(step_out),
        .dir_out(dir_out),
        .busy(busy),
        .done(done),
        .steps_done(steps_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Run one move; cycle c is the cycle after the c-th rising edge counted from the accept edge.
    task automatic run_move(input logic d, input int steps, input int period, input int pw,
                            input int abort_c, input bit junk, input int rst_c);
        int pwe, pere, nat_done, done_c, emitted, r, exp_sd;
        bit in_pulse;
        logic exp_step;
        pwe  = (pw < 1) ? 1 : pw;
        pere = (period < pwe + 1) ? pwe + 1 : period;
        nat_done = (steps == 0) ? 1 : 1 + DS + steps * pere;
        done_c   = nat_done;
        emitted  = steps;
        if (steps > 0 && abort_c >= 1 && abort_c < nat_done) begin
            in_pulse = 1'b0;
            for (int k = 0; k < steps; k++) begin
                r = 1 + DS + k * pere;
                if (abort_c >= r && abort_c < r + pwe) begin
                    done_c   = r + pwe;
                    emitted  = k + 1;
                    in_pulse = 1'b1;
                end
            end
            if (!in_pulse) begin
                emitted = 0;
                for (int k = 0; k < steps; k++) begin
                    if (1 + DS + k * pere <= abort_c) emitted++;
                end
                done_c = abort_c + 1;
            end
        end
        if (steps > 0) exp_dir = d;

        @(negedge clk);
        chk("ready_at_accept", cmd_ready, 1);
        cmd_valid       = 1'b1;
        cmd_dir         = d;
        cmd_steps       = 32'(steps);
        cmd_period      = 32'(period);
        cmd_pulse_width = 16'(pw);
        abort           = 1'b0;

        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk);
            exp_step = 1'b0;
            exp_sd   = 0;
            for (int k = 0; k < emitted; k++) begin
                r = 1 + DS + k * pere;
                if (c >= r && c < r + pwe) exp_step = 1'b1;
                if (c >= r + pwe) exp_sd++;
            end
            chk("step_out", step_out, exp_step);
            chk("dir_out", dir_out, exp_dir);
            chk("busy", busy, (steps > 0 && c < done_c) ? 1 : 0);
            chk("done", done, (c == done_c) ? 1 : 0);
            chk("steps_done", steps_done, exp_sd);
            chk("cmd_ready", cmd_ready, (c > done_c) ? 1 : 0);
            if (c == rst_c) begin
                rst = 1'b1;
                #1;
                chk("rst_step_out", step_out, 0);
                chk("rst_busy", busy, 0);
                chk("rst_steps_done", steps_done, 0);
                chk("rst_dir_out", dir_out, 0);
                exp_dir   = 1'b0;
                cmd_valid = 1'b0;
                abort     = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            cmd_valid = junk && (c < done_c);
            if (cmd_valid) begin
                cmd_dir         = 1'($urandom_range(0, 1));
                cmd_steps       = $urandom_range(0, 9);
                cmd_period      = $urandom_range(0, 20);
                cmd_pulse_width = 16'($urandom_range(0, 9));
            end
            abort = (c == abort_c);
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
    endtask

    initial begin
        n_total         = 0;
        n_bad           = 0;
        exp_dir         = 1'b0;
        rst             = 1'b1;
        cmd_valid       = 1'b0;
        cmd_dir         = 1'b0;
        cmd_steps       = 32'd0;
        cmd_period      = 32'd0;
        cmd_pulse_width = 16'd0;
        abort           = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_step_out", step_out, 0);
        chk("reset_dir_out", dir_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_steps_done", steps_done, 0);
        chk("reset_cmd_ready", cmd_ready, 1);

        run_move(1'b1, 3, 10, 3, 0, 1'b0, 0);
        run_move(1'b0, 0, 7, 2, 0, 1'b0, 0);
        run_move(1'b1, 3, 10, 3, 16, 1'b0, 0);
        run_move(1'b0, 2, 1, 5, 0, 1'b1, 0);
        run_move(1'b1, 3, 10, 3, 0, 1'b0, 6);
        run_move(1'b1, 3, 10, 3, 0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            run_move(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : 0,
                     1'($urandom_range(0, 1)), 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
